// File: rtl/instr_fetcher_pkg.sv
// instr_fetcher_pkg: fetch FSM states, queue entry type and JAL target helper (FETCH_JAL_PREDICT_EN)
package instr_fetcher_pkg;
  typedef enum logic [1:0] {IF_IDLE, IF_WAIT, IF_DISCARD} if_state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } iq_entry_t;
`ifdef FETCH_JAL_PREDICT_EN
  localparam logic [6:0] OPCODE_JAL = 7'b1101111;
  function automatic logic [31:0] jal_imm(input logic [31:0] w);
    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
  endfunction
`endif
endpackage

// File: rtl/instr_fetcher_queue.sv
// instr_queue: circular FIFO of fetched {pc, instr} entries with synchronous clear
module instr_queue
  import instr_fetcher_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  input  logic      push,
  input  logic      pop,
  input  logic      clear,
  input  iq_entry_t push_data,
  output iq_entry_t head,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  iq_entry_t mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  assign full = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign head = mem_q[head_q];
  always_comb begin
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    head_d = clear ? '0 : head_q + AW'(do_pop);
    tail_d = clear ? '0 : tail_q + AW'(do_push);
    count_d = clear ? '0 : count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else if (rdy) begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rdy && do_push && !clear) mem_q[tail_q] <= push_data;
  end
endmodule

// File: rtl/instr_fetcher.sv
// instr_fetcher: fetch FSM feeding an instruction queue; FETCH_JAL_PREDICT_EN follows JAL targets at fetch
module instr_fetcher
  import instr_fetcher_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          IQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_done,
  input  logic [31:0] mc_data,
  input  logic        id_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        flush,
  input  logic [31:0] flush_pc
);
  if_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, addr_q, addr_d, pc_step;
  logic req_q, req_d, push, issue, full, empty;
  iq_entry_t head, fetched;
`ifdef FETCH_JAL_PREDICT_EN
  assign pc_step = (mc_data[6:0] == OPCODE_JAL) ? jal_imm(mc_data) : 32'd4;
`else
  assign pc_step = 32'd4;
`endif
  assign fetched = '{pc: pc_q, instr: mc_data};
  assign mc_req = req_q;
  assign mc_addr = addr_q;
  assign instr_valid = !empty;
  assign instr = head.instr;
  assign instr_pc = head.pc;
  always_comb begin
    state_d = state_q;
    pc_d = flush ? flush_pc : pc_q;
    addr_d = addr_q;
    req_d = req_q;
    push = 1'b0;
    issue = !flush && !full;
    case (state_q)
      IF_IDLE: begin
        req_d = issue;
        addr_d = issue ? {pc_q[31:2], 2'b00} : addr_q;
        state_d = issue ? IF_WAIT : IF_IDLE;
      end
      IF_WAIT: begin
        push = mc_done && !flush;
        pc_d = flush ? flush_pc : mc_done ? pc_q + pc_step : pc_q;
        req_d = !mc_done;
        state_d = mc_done ? IF_IDLE : flush ? IF_DISCARD : IF_WAIT;
      end
      IF_DISCARD: begin
        req_d = !mc_done;
        state_d = mc_done ? IF_IDLE : IF_DISCARD;
      end
      default: state_d = IF_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IF_IDLE;
      pc_q <= RESET_PC;
      addr_q <= '0;
      req_q <= 1'b0;
    end else if (rdy) begin
      state_q <= state_d;
      pc_q <= pc_d;
      addr_q <= addr_d;
      req_q <= req_d;
    end
  end
  instr_queue #(.DEPTH(IQ_DEPTH)) u_iq (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .push(push),
    .pop(id_ready),
    .clear(flush),
    .push_data(fetched),
    .head(head),
    .full(full),
    .empty(empty)
  );
endmodule
